// File: rtl/instruction_fetch_if.sv
// Bus bundle between the instruction fetch unit, instruction memory and the decoder.
// master = fetch unit, slave = memory/decoder side.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  ir_ready;

  modport master (
    output mem_req, mem_addr, ir, ir_pc, ir_valid,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_pc, ir_valid,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads mem[pc] over req/ack, holds the byte for the decoder.
// Define FETCH_TIMEOUT_EN to enable the sticky fetch watchdog (fetch_err).
module instruction_fetch #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_enable,
  input  logic                  flush,
  output logic                  fetch_err,
  instruction_fetch_if.master   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_base_s;
  logic [1:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] fetch_addr_r;
  logic [ADDR_WIDTH-1:0] ir_pc_r;
  logic [DATA_WIDTH-1:0] ir_r;
  logic                  ir_valid_r;
  logic                  load_addr_s;
  logic                  capture_s;
  logic                  busy_s;
  logic                  timeout_hit_s;

  // Request is decoded from the state register only, so it never glitches on inputs.
  assign busy_s       = (state_r == REQ) || (state_r == DRAIN);
  assign bus.mem_req  = busy_s;
  assign bus.mem_addr = fetch_addr_r;
  assign bus.ir       = ir_r;
  assign bus.ir_pc    = ir_pc_r;
  assign bus.ir_valid = ir_valid_r;
  assign pc_enable    = (state_r == REQ) && bus.mem_ack && !flush;
  assign state_nxt_s  = timeout_hit_s ? IDLE : state_base_s;

  // Next-state decode for the fetch handshake.
  always_comb begin
    state_base_s = state_r;
    load_addr_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!flush) begin
          state_base_s = REQ;
          load_addr_s  = 1'b1;
        end else begin
          state_base_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack && !flush) begin
          state_base_s = HOLD;
          capture_s    = 1'b1;
        end else if (bus.mem_ack) begin
          state_base_s = IDLE;
        end else if (flush) begin
          state_base_s = DRAIN;
        end else begin
          state_base_s = REQ;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          state_base_s = IDLE;
        end else begin
          state_base_s = DRAIN;
        end
      end
      HOLD: begin
        // Flush wins over ir_ready: the held instruction is on the wrong path.
        if (flush) begin
          state_base_s = IDLE;
        end else if (bus.ir_ready) begin
          state_base_s = REQ;
          load_addr_s  = 1'b1;
        end else begin
          state_base_s = HOLD;
        end
      end
      default: begin
        state_base_s = IDLE;
      end
    endcase
  end

  // State, fetch address and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      fetch_addr_r <= {ADDR_WIDTH{1'b0}};
      ir_r         <= {DATA_WIDTH{1'b0}};
      ir_pc_r      <= {ADDR_WIDTH{1'b0}};
      ir_valid_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ir_valid_r <= (state_nxt_s == HOLD);
      if (load_addr_s) begin
        fetch_addr_r <= pc;
      end
      if (capture_s) begin
        ir_r    <= bus.mem_rdata;
        ir_pc_r <= fetch_addr_r;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             fetch_err_r;
  logic             enter_s;

  // Re-entering REQ or moving REQ->DRAIN restarts the wait count.
  assign enter_s       = ((state_nxt_s == REQ) || (state_nxt_s == DRAIN)) && (state_nxt_s != state_r);
  assign timeout_hit_s = busy_s && !bus.mem_ack && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err     = fetch_err_r;

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r   <= {CNT_W{1'b0}};
      fetch_err_r <= 1'b0;
    end else begin
      if (timeout_hit_s) begin
        fetch_err_r <= 1'b1;
      end
      if (enter_s) begin
        tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (busy_s && !bus.mem_ack) begin
        tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign fetch_err     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised self-checking bench for instruction_fetch against a transaction-level model,
// plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch;
  localparam int TMO = 15;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic       pc_enable;
  logic       flush;
  logic       fetch_err;

  instruction_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  instruction_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .pc_enable (pc_enable),
    .flush     (flush),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [256];

  // Model: an outstanding request (possibly to be discarded) or a held instruction.
  bit         m_busy, m_disc, m_held, m_err;
  logic [7:0] m_addr, m_ir, m_irpc;
  int         m_wait;

  bit          chk_en = 1'b0;
  bit          pce_seen, exp_pce;
  int          req_cycles, pce_count, valid_cycles;
  logic [7:0]  last_req_addr;
  logic [31:0] valid_mask;
  logic [15:0] acc_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_disc = 1'b0; m_held = 1'b0; m_err = 1'b0;
    m_addr = 8'h00; m_ir = 8'h00; m_irpc = 8'h00; m_wait = 0;
  endtask

  task automatic model_update();
    if (m_held) begin
      if (flush) begin
        m_held = 1'b0;
      end else if (bus.ir_ready) begin
        m_held = 1'b0; m_busy = 1'b1; m_disc = 1'b0; m_addr = pc; m_wait = 0;
      end
    end else if (m_busy) begin
      if (bus.mem_ack) begin
        m_busy = 1'b0;
        if (!m_disc && !flush) begin
          m_held = 1'b1; m_ir = bus.mem_rdata; m_irpc = m_addr;
        end
      end else begin
`ifdef FETCH_TIMEOUT_EN
        if (m_wait == TMO - 1) begin
          m_err = 1'b1; m_busy = 1'b0;
        end else
`endif
        if (flush && !m_disc) begin
          m_disc = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end
    end else if (!flush) begin
      m_busy = 1'b1; m_disc = 1'b0; m_addr = pc; m_wait = 0;
    end
  endtask

  task automatic clear_logs();
    req_cycles = 0; pce_count = 0; valid_cycles = 0; valid_mask = 32'd0;
    acc_q.delete();
  endtask

  // The single compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_pce = m_busy && !m_disc && bus.mem_ack && !flush;
      cmp("mem_req", bus.mem_req, m_busy);
      if (m_busy) cmp("mem_addr", bus.mem_addr, m_addr);
      cmp("ir_valid", bus.ir_valid, m_held);
      if (m_held) begin
        cmp("ir", bus.ir, m_ir);
        cmp("ir_pc", bus.ir_pc, m_irpc);
      end
      cmp("pc_enable", pc_enable, exp_pce);
      cmp("fetch_err", fetch_err, m_err);
      pce_seen = pc_enable;
      if (bus.mem_req) begin
        req_cycles++;
        last_req_addr = bus.mem_addr;
      end
      pce_count    += int'(pc_enable);
      valid_cycles += int'(bus.ir_valid);
      valid_mask    = {valid_mask[30:0], bus.ir_valid};
      if (bus.ir_valid && bus.ir_ready && !flush) acc_q.push_back({bus.ir_pc, bus.ir});
    end else begin
      pce_seen = 1'b0;
    end
  end

  // One clock cycle: apply inputs at posedge+1, advance model and pc at the edge.
  task automatic step(input bit f, input logic [7:0] tgt, input bit rdy, input bit ak);
    flush         = f;
    bus.ir_ready  = rdy;
    bus.mem_ack   = ak & bus.mem_req;
    bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr] : 8'($urandom);
    @(posedge clk);
    model_update();
    #1;
    if (f) pc = tgt;
    else if (pce_seen) pc = pc + 8'd1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1; flush = 1'b0; bus.ir_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; pc = 8'h00; flush = 1'b0;
    bus.ir_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    @(posedge clk);
    #1;
    cmp("reset_mem_req", bus.mem_req, 1'b0);
    cmp("reset_ir_valid", bus.ir_valid, 1'b0);
    cmp("reset_ir_pc", bus.ir_pc, 8'h00);

    // Zero-wait stream of three instructions.
    pc = 8'h00;
    do_reset();
    clear_logs();
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    cmp("zw_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      cmp("zw_i0", acc_q[0], 16'h0010);
      cmp("zw_i1", acc_q[1], 16'h0120);
      cmp("zw_i2", acc_q[2], 16'h0230);
    end
    cmp("zw_pce", pce_count, 3);
    cmp("zw_valid_pattern", valid_mask[6:0], 7'h15);

    // Three wait states at pc=0x05.
    pc = 8'h05;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    clear_logs();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    cmp("ws_req_cycles", req_cycles, 4);
    cmp("ws_addr", last_req_addr, 8'h05);
    cmp("ws_pce", pce_count, 1);

    // Decoder stalls for five cycles.
    clear_logs();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("stall_no_req", req_cycles, 0);
    cmp("stall_valid", valid_cycles, 5);
    cmp("stall_ir_pc", bus.ir_pc, 8'h05);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("stall_next_addr", last_req_addr, 8'h06);

    // Flush while the request is outstanding, jump to 0x40.
    clear_logs();
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("drain_pce", pce_count, 0);
    cmp("drain_req_cycles", req_cycles, 3);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("jump_addr", last_req_addr, 8'h40);
    cmp("jump_ir_pc", bus.ir_pc, 8'h40);
    cmp("jump_ir", bus.ir, mem[8'h40]);

    // Flush with ir_ready in HOLD, jump to 0xFF and wrap.
    clear_logs();
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    cmp("flush_ir_valid", bus.ir_valid, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    cmp("wrap_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      cmp("wrap_pc0", acc_q[0][15:8], 8'hFF);
      cmp("wrap_pc1", acc_q[1][15:8], 8'h00);
    end

    // Asynchronous reset in the middle of a fetch.
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    cmp("async_reset_mem_req", bus.mem_req, 1'b0);
    cmp("async_reset_ir_valid", bus.ir_valid, 1'b0);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory never acknowledges.
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < TMO; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("tmo_err", fetch_err, 1'b1);
    cmp("tmo_req_drop", bus.mem_req, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("tmo_sticky", fetch_err, 1'b1);
    do_reset();
    cmp("tmo_cleared", fetch_err, 1'b0);
`endif

    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Consumer side of the program counter in the 8-bit CPU.
- Reads the current `pc`, issues a read to instruction memory over a req/ack handshake and captures the returned byte into an instruction register.
- Pulses `pc_enable` so the program counter advances exactly once per accepted fetch.
- Presents the instruction to the decoder with a valid/ready handshake, and supports flushing on control-flow change.

## Interface
- `ADDR_WIDTH`, default 8: width of `pc`, `mem_addr`, `ir_pc`.
- `DATA_WIDTH`, default 8: width of `mem_rdata`, `ir`.
- `TIMEOUT_CYCLES`, default 15: watchdog limit. Used only with `FETCH_TIMEOUT_EN`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc` in ADDR_WIDTH: current program counter value.
- `pc_enable` out 1: increment strobe to the program counter.
- `mem_req` out 1: memory read request.
- `mem_addr` out ADDR_WIDTH: read address, stable while `mem_req`=1.
- `mem_ack` in 1: memory ack. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_WIDTH: read data.
- `flush` in 1: discard the held or in-flight fetch. `pc` is being reloaded this cycle.
- `ir` out DATA_WIDTH: instruction byte.
- `ir_pc` out ADDR_WIDTH: address that `ir` was fetched from.
- `ir_valid` out 1: `ir`/`ir_pc` valid.
- `ir_ready` in 1: decoder accepts the instruction.
- `fetch_err` out 1: sticky watchdog error.

## Operation
- FSM states: IDLE, REQ, HOLD, DRAIN. Internal register `fetch_addr`.
- Reset value: state=IDLE; `ir`, `ir_pc`, `fetch_addr`=0; `ir_valid`, `fetch_err`=0. `mem_req`, `pc_enable`=0 during reset.
- `mem_req` = (state==REQ or DRAIN), decoded from the state register only.
- `mem_addr` = `fetch_addr`.
- `pc_enable` = (state==REQ) & `mem_ack` & ~`flush`. It is combinational, so the PC updates on the same edge the data is captured.
- IDLE:
  - `flush`=0 → REQ, with `fetch_addr`←`pc`.
  - `flush`=1 → stay in IDLE.
- REQ:
  - `mem_ack` & ~`flush` → HOLD; `ir`←`mem_rdata`, `ir_pc`←`fetch_addr`, `ir_valid`←1.
  - `mem_ack` & `flush` → IDLE; data is discarded, no `pc_enable`.
  - ~`mem_ack` & `flush` → DRAIN.
  - Otherwise stay in REQ.
- DRAIN:
  - Keeps `mem_req`=1 until `mem_ack`; the protocol forbids withdrawing a request.
  - On ack → IDLE; data is discarded.
  - `flush` has no further effect in this state.
- HOLD:
  - `flush` → IDLE, `ir_valid`←0. `flush` takes priority over `ir_ready`.
  - Else `ir_ready` → REQ; `ir_valid`←0, `fetch_addr`←`pc` (the already-incremented value).
  - Else stay in HOLD; `ir`/`ir_pc` are held stable.
- `ir_valid`=1 exactly in HOLD.
- Address wrap: the PC increments modulo 2^ADDR_WIDTH; `fetch_addr`=0xFF followed by 0x00 is legal.

## Timing
- Zero-wait memory (ack in the first REQ cycle) gives:
  - REQ at cycle N, `ir_valid` at N+1.
  - If `ir_ready` is high at N+1, the next REQ is at N+2.
  - Peak throughput is 1 instruction per 2 cycles.
- Each wait state adds one cycle.
- From reset deassertion: IDLE for 1 cycle, then REQ.
- Flush latency:
  - `ir_valid` low on the cycle after `flush`.
  - New fetch starts 1 cycle after `flush` drops (IDLE→REQ), using the reloaded `pc`.
- Reset asserted mid-fetch forces IDLE immediately and drops `mem_req` asynchronously.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ/DRAIN and counts cycles in REQ/DRAIN without `mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`: `fetch_err`←1 (sticky until reset), state→IDLE, `mem_req` drops.
  - The fetch is then re-issued from the current `pc`.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter; the block waits for `mem_ack` indefinitely.
  - `fetch_err` is tied to 0.

## Test plan
- Zero-wait memory, image [0x10,0x20,0x30], `ir_ready`=1, `pc` model increments on `pc_enable`:
  - `ir`/`ir_pc` sequence = 0x10/0, 0x20/1, 0x30/2.
  - `ir_valid` high every other cycle.
  - Exactly 3 `pc_enable` pulses.
- Ack delayed 3 cycles, `pc`=0x05:
  - `mem_req` high 4 cycles with `mem_addr`=0x05 stable.
  - `pc_enable` is a single pulse.
- `ir_ready`=0 for 5 cycles in HOLD:
  - `ir`, `ir_pc` and `ir_valid`=1 are held.
  - No new `mem_req`.
  - `ir_ready`=1 → REQ at `pc`+1.
- `flush` during REQ without ack, then jump to `pc`=0x40:
  - DRAIN holds `mem_req` until ack.
  - Drained data is not captured and there is no `pc_enable`.
  - Next fetch uses `mem_addr`=0x40.
- `flush` and `ir_ready` together in HOLD:
  - `ir_valid`=0 next cycle, state IDLE.
  - `pc` at 0xFF wraps to fetch 0x00.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=15, `mem_ack` stuck low:
  - `fetch_err` rises after 15 REQ cycles and stays high.
  - `mem_req` drops.
  - Reset clears `fetch_err`.
